uart_tx_serializer: RTL and testbench
=====================================

# uart_tx_serializer

Parametrised UART transmit engine that supersedes the fixed 8-bit TX data mux plus its external bit timer. It accepts a word over a valid/ready handshake and owns its baud timing internally. It serialises a complete frame: start bit, DATA_W data bits LSB first, optional even/odd parity, and one or two stop bits. It sits between the bus-side TX register/FIFO and the `tx` pin of the UART top.

## Interface
- DATA_W, default 8: data bits per frame, legal range 5..9.
- CLKS_PER_BIT, default 868: clk cycles per bit (100 MHz / 115200), legal range ≥ 2.
- CNT_W, default $clog2(CLKS_PER_BIT): bit-timer width (derived, not overridden).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- tx_data  in  DATA_W  word to send.
- tx_valid  in  1  word is valid.
- tx_ready  out  1  engine can accept a word (IDLE only).
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none.
- stop2  in  1  0: one stop bit, 1: two stop bits.
- tx  out  1  serial line, registered, idle high.
- busy  out  1  frame in progress (state ≠ IDLE).
- tx_done  out  1  one-cycle pulse at frame completion.

## Operation
- Reset values: tx=1, tx_ready=1, busy=0, tx_done=0, state=IDLE, bit timer=0, bit index=0.
- Handshake: a transfer occurs at the posedge where tx_valid && tx_ready. tx_data, parity_mode and stop2 are latched at that edge. Input changes during a frame have no effect.
- States and transitions:
  - IDLE → START on transfer.
  - START → DATA on end_bit.
  - DATA → DATA while index < DATA_W-1 on end_bit, with index+1.
  - DATA → PARITY on end_bit at the last index if parity is enabled, otherwise → STOP.
  - PARITY → STOP on end_bit.
  - STOP → STOP once more if stop2 is latched and this was the first stop bit.
  - STOP → IDLE on end_bit of the last stop bit.
- end_bit = (bit timer == CLKS_PER_BIT-1). The timer clears on transfer and on every end_bit, and increments otherwise while busy.
- tx is updated on the same edge as the state change, and takes the value of the new state:
  - START: 0.
  - DATA: latched_data[index].
  - PARITY: ^latched_data for even, ~^latched_data for odd.
  - STOP and IDLE: 1.
- Parity is computed over the DATA_W latched bits only.
- Illegal state encodings recover to IDLE with tx=1.

## Timing
- Latency: tx falls on the transfer edge itself; the start bit is visible the following cycle.
- Every bit, including each stop bit, lasts exactly CLKS_PER_BIT cycles.
- Frame length = (1 + DATA_W + P + S) × CLKS_PER_BIT cycles, where P∈{0,1} and S∈{1,2}.
- On the edge ending the last stop bit:
  - state → IDLE and tx_ready → 1;
  - tx_done is high for that one cycle only.
- Back-to-back frames: with tx_valid held high, the next transfer occurs on the edge after the IDLE cycle. The line is therefore high for S×CLKS_PER_BIT+1 cycles between frames.
- tx_valid while busy is ignored; no word is lost only because the source must hold it until tx_ready.
- Reset mid-frame: tx returns to 1 immediately (asynchronous); the partial frame is abandoned and no tx_done is produced.

## Structure
- Package uart_pkg contains:
  - state localparams IDLE=0, START=1, DATA=2, PARITY=3, STOP=4 (3-bit);
  - parity-mode constants PAR_NONE, PAR_EVEN, PAR_ODD;
  - line constants TX_IDLE=1, TX_START=0, TX_STOP=1.
- One sub-module, uart_bit_timer (params CLKS_PER_BIT; ports clk, rst, clear, run, end_bit), reusable by the RX side.
- Serializer FSM, data/config latches and output register live in the top module.

## Test plan
All runs use CLKS_PER_BIT=4 and DATA_W=8 unless stated.
- Reset: assert rst mid-sim → tx=1, tx_ready=1, busy=0 within the same cycle, and held through release.
- 8N1, tx_data=0x55, no parity, stop2=0 → line is 0,1,0,1,0,1,0,1,0,1, each bit 4 clks. tx_done pulses at 40 clks after transfer.
- 8E2 with 0x07 → parity bit 1, two stop bits, frame 48 clks. 8O1 with 0x07 → parity bit 0.
- DATA_W=5, odd parity, 0x1F → 5 data ones then parity 0. Frame 32 clks.
- Back-to-back: tx_valid held with 0xA5 then 0x3C → second start bit begins exactly 1 clk after the first tx_done. tx_data changes mid-frame do not alter bits being sent.
- Reset asserted during DATA bit 3 → tx=1 immediately, no tx_done. The next frame after release is transmitted correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the UART TX/RX slice: FSM state codes, parity modes,
// line levels and the parity helpers.
package uart_pkg;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   localparam logic TX_IDLE  = 1'b1;
   localparam logic TX_START = 1'b0;
   localparam logic TX_STOP  = 1'b1;

   // Mode 2'b11 is reserved and behaves like PAR_NONE.
   function automatic logic parity_enabled(input logic [1:0] mode);
      return (mode == PAR_EVEN) || (mode == PAR_ODD);
   endfunction

   // Data is zero-extended to 9 bits by the caller; the padding does not affect XOR.
   function automatic logic parity_bit(input logic [8:0] data, input logic [1:0] mode);
      return (mode == PAR_ODD) ? ~^data : ^data;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Per-bit baud timer: end_bit marks the last clk of each CLKS_PER_BIT-long bit.
// Shared by the TX serializer and the RX side.
module uart_bit_timer #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic run,
   output logic end_bit
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);

   logic [CNT_W-1:0] r_cnt;
   logic             w_end_bit;

   assign w_end_bit = run && (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
   assign end_bit   = w_end_bit;

   // Bit counter: restarts on a new frame and at every bit boundary.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (clear || w_end_bit) begin
         r_cnt <= '0;
      end else if (run) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end else begin
         r_cnt <= r_cnt;
      end
   end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit engine: valid/ready word intake, start + DATA_W bits LSB first,
// optional parity and one or two stop bits, with its own baud timing.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 868
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   input  logic [1:0]        parity_mode,
   input  logic              stop2,
   output logic              tx,
   output logic              busy,
   output logic              tx_done
);

   localparam int IDX_W = $clog2(DATA_W);

   logic [2:0]        r_state, w_state_nx;
   logic [IDX_W-1:0]  r_idx, w_idx_nx;
   logic              r_stop_idx, w_stop_idx_nx;
   logic [DATA_W-1:0] r_data;
   logic [1:0]        r_par_mode;
   logic              r_stop2;
   logic              r_tx, r_ready, r_busy, r_done;
   logic              w_tx_nx, w_done_nx;
   logic              w_transfer, w_end_bit;
   logic [DATA_W-1:0] w_data_sh;
   logic [8:0]        w_data_ext;

   assign w_transfer = tx_valid && r_ready;

   uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (w_transfer),
      .run     (r_busy),
      .end_bit (w_end_bit)
   );

   // State, frame latches and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_idx      <= '0;
         r_stop_idx <= 1'b0;
         r_data     <= '0;
         r_par_mode <= PAR_NONE;
         r_stop2    <= 1'b0;
         r_tx       <= TX_IDLE;
         r_ready    <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nx;
         r_idx      <= w_idx_nx;
         r_stop_idx <= w_stop_idx_nx;
         if (w_transfer) begin
            r_data     <= tx_data;
            r_par_mode <= parity_mode;
            r_stop2    <= stop2;
         end else begin
            r_data     <= r_data;
            r_par_mode <= r_par_mode;
            r_stop2    <= r_stop2;
         end
         r_tx    <= w_tx_nx;
         r_ready <= (w_state_nx == IDLE);
         r_busy  <= (w_state_nx != IDLE);
         r_done  <= w_done_nx;
      end
   end

   // Next-state and bit/stop index sequencing.
   always_comb begin
      w_state_nx    = r_state;
      w_idx_nx      = r_idx;
      w_stop_idx_nx = r_stop_idx;
      case (r_state)
         IDLE: begin
            if (w_transfer) w_state_nx = START;
            else            w_state_nx = IDLE;
         end
         START: begin
            if (w_end_bit) begin
               w_state_nx = DATA;
               w_idx_nx   = '0;
            end else begin
               w_state_nx = START;
            end
         end
         DATA: begin
            if (!w_end_bit) begin
               w_state_nx = DATA;
            end else if (r_idx < IDX_W'(DATA_W - 1)) begin
               w_idx_nx = r_idx + IDX_W'(1);
            end else if (parity_enabled(r_par_mode)) begin
               w_state_nx = PARITY;
            end else begin
               w_state_nx    = STOP;
               w_stop_idx_nx = 1'b0;
            end
         end
         PARITY: begin
            if (w_end_bit) begin
               w_state_nx    = STOP;
               w_stop_idx_nx = 1'b0;
            end else begin
               w_state_nx = PARITY;
            end
         end
         STOP: begin
            if (!w_end_bit) begin
               w_state_nx = STOP;
            end else if (r_stop2 && !r_stop_idx) begin
               w_stop_idx_nx = 1'b1;
            end else begin
               w_state_nx = IDLE;
            end
         end
         default: begin
            w_state_nx    = IDLE;
            w_idx_nx      = '0;
            w_stop_idx_nx = 1'b0;
         end
      endcase
   end

   assign w_data_sh = r_data >> w_idx_nx;

   // Line level follows the state being entered, so tx moves on the transition edge.
   always_comb begin
      w_data_ext               = '0;
      w_data_ext[DATA_W-1:0]   = r_data;
      w_tx_nx                  = TX_IDLE;
      case (w_state_nx)
         START:   w_tx_nx = TX_START;
         DATA:    w_tx_nx = w_data_sh[0];
         PARITY:  w_tx_nx = parity_bit(w_data_ext, r_par_mode);
         STOP:    w_tx_nx = TX_STOP;
         IDLE:    w_tx_nx = TX_IDLE;
         default: w_tx_nx = TX_IDLE;
      endcase
      if ((r_state == STOP) && (w_state_nx == IDLE)) w_done_nx = 1'b1;
      else                                           w_done_nx = 1'b0;
   end

   assign tx       = r_tx;
   assign tx_ready = r_ready;
   assign busy     = r_busy;
   assign tx_done  = r_done;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench: expected line levels per clk are queued when a word is
// offered and popped against the serial line of an 8-bit and a 5-bit engine.
module tb_uart_tx_serializer;
   import uart_pkg::*;

   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic [1:0] pmode = 2'b00;
   logic       stop2 = 1'b0;
   logic       valid8 = 1'b0, valid5 = 1'b0;
   logic       ready8, tx8, busy8, done8;
   logic       ready5, tx5, busy5, done5;

   int   n_assert = 0;
   int   n_fail   = 0;
   logic exp_q[$];

   always #5 clk = ~clk;

   uart_tx_serializer #(.DATA_W(8), .CLKS_PER_BIT(CPB)) u_dut8 (
      .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid8), .tx_ready(ready8),
      .parity_mode(pmode), .stop2(stop2), .tx(tx8), .busy(busy8), .tx_done(done8));

   uart_tx_serializer #(.DATA_W(5), .CLKS_PER_BIT(CPB)) u_dut5 (
      .clk(clk), .rst(rst), .tx_data(tx_data[4:0]), .tx_valid(valid5), .tx_ready(ready5),
      .parity_mode(pmode), .stop2(stop2), .tx(tx5), .busy(busy5), .tx_done(done5));

   function automatic logic cur_tx(input int sel);    return (sel == 5) ? tx5 : tx8;       endfunction
   function automatic logic cur_done(input int sel);  return (sel == 5) ? done5 : done8;   endfunction
   function automatic logic cur_busy(input int sel);  return (sel == 5) ? busy5 : busy8;   endfunction
   function automatic logic cur_ready(input int sel); return (sel == 5) ? ready5 : ready8; endfunction

   task automatic push_bit(input logic b);
      for (int i = 0; i < CPB; i++) exp_q.push_back(b);
   endtask

   // Reference frame built from the line format, not from the design's logic.
   task automatic push_frame(input logic [7:0] d, input int w, input logic [1:0] pm, input logic s2);
      int ones;
      ones = 0;
      push_bit(1'b0);
      for (int i = 0; i < w; i++) begin
         push_bit(d[i]);
         if (d[i]) ones++;
      end
      if (pm == PAR_EVEN) push_bit((ones % 2) == 1);
      if (pm == PAR_ODD)  push_bit((ones % 2) == 0);
      push_bit(1'b1);
      if (s2) push_bit(1'b1);
   endtask

   // Called at a negedge; returns at the first negedge after the transfer edge.
   task automatic start_word(input int sel, input logic [7:0] d, input logic [1:0] pm,
                             input logic s2, input bit hold);
      n_assert++;
      if (cur_ready(sel) !== 1'b1) begin
         n_fail++;
         $display("FAIL ready_before_send dut%0d: tx_ready=%b expected 1", sel, cur_ready(sel));
      end
      tx_data = d; pmode = pm; stop2 = s2;
      if (sel == 5) valid5 = 1'b1; else valid8 = 1'b1;
      @(negedge clk);
      if (!hold) begin
         valid5 = 1'b0; valid8 = 1'b0;
      end
   endtask

   // Pops one expected level per clk until tx_done; stops on the tx_done cycle.
   task automatic drain(input int sel, input string name, input int exp_len);
      int   n;
      logic e;
      n = 0;
      while (cur_done(sel) !== 1'b1 && n < 200) begin
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b1;
         n_assert++;
         if (cur_tx(sel) !== e) begin
            n_fail++;
            $display("FAIL %s line cycle %0d: tx=%b expected %b", name, n, cur_tx(sel), e);
         end
         n_assert++;
         if (cur_busy(sel) !== 1'b1 || cur_ready(sel) !== 1'b0) begin
            n_fail++;
            $display("FAIL %s status cycle %0d: busy=%b ready=%b expected 1/0",
                     name, n, cur_busy(sel), cur_ready(sel));
         end
         n++;
         @(negedge clk);
      end
      n_assert++;
      if (n !== exp_len) begin
         n_fail++;
         $display("FAIL %s frame_length: %0d clks expected %0d", name, n, exp_len);
      end
      n_assert++;
      if (cur_done(sel) !== 1'b1 || cur_ready(sel) !== 1'b1 || cur_busy(sel) !== 1'b0 || cur_tx(sel) !== 1'b1) begin
         n_fail++;
         $display("FAIL %s end_state: done=%b ready=%b busy=%b tx=%b expected 1/1/0/1",
                  name, cur_done(sel), cur_ready(sel), cur_busy(sel), cur_tx(sel));
      end
      exp_q.delete();
   endtask

   task automatic done_drops(input int sel, input string name);
      @(negedge clk);
      n_assert++;
      if (cur_done(sel) !== 1'b0 || cur_tx(sel) !== 1'b1) begin
         n_fail++;
         $display("FAIL %s done_pulse_width: done=%b tx=%b expected 0/1", name, cur_done(sel), cur_tx(sel));
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_assert++;
      if (tx8 !== 1'b1 || ready8 !== 1'b1 || busy8 !== 1'b0 || done8 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_values: tx=%b ready=%b busy=%b done=%b expected 1/1/0/0", tx8, ready8, busy8, done8);
      end
      rst = 1'b0;
      @(negedge clk);
      n_assert++;
      if (tx8 !== 1'b1 || ready8 !== 1'b1 || busy8 !== 1'b0 || tx5 !== 1'b1 || ready5 !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release: tx8=%b ready8=%b busy8=%b tx5=%b ready5=%b expected 1/1/0/1/1",
                  tx8, ready8, busy8, tx5, ready5);
      end
   endtask

   task automatic test_8n1();
      push_frame(8'h55, 8, PAR_NONE, 1'b0);
      start_word(8, 8'h55, PAR_NONE, 1'b0, 1'b0);
      drain(8, "8N1_55", 40);
      done_drops(8, "8N1_55");
      push_frame(8'hC3, 8, 2'b11, 1'b1);
      start_word(8, 8'hC3, 2'b11, 1'b1, 1'b0);
      drain(8, "8N2_mode3_C3", 44);
      done_drops(8, "8N2_mode3_C3");
   endtask

   task automatic test_parity();
      push_frame(8'h07, 8, PAR_EVEN, 1'b1);
      start_word(8, 8'h07, PAR_EVEN, 1'b1, 1'b0);
      pmode = PAR_NONE; stop2 = 1'b0;
      drain(8, "8E2_07", 48);
      done_drops(8, "8E2_07");
      push_frame(8'h07, 8, PAR_ODD, 1'b0);
      start_word(8, 8'h07, PAR_ODD, 1'b0, 1'b0);
      drain(8, "8O1_07", 44);
      done_drops(8, "8O1_07");
      push_frame(8'h1F, 5, PAR_ODD, 1'b0);
      start_word(5, 8'h1F, PAR_ODD, 1'b0, 1'b0);
      drain(5, "5O1_1F", 32);
      done_drops(5, "5O1_1F");
   endtask

   task automatic test_back_to_back();
      push_frame(8'hA5, 8, PAR_NONE, 1'b0);
      start_word(8, 8'hA5, PAR_NONE, 1'b0, 1'b1);
      tx_data = 8'h3C;
      drain(8, "b2b_A5", 40);
      push_frame(8'h3C, 8, PAR_NONE, 1'b0);
      @(negedge clk);
      valid8  = 1'b0;
      tx_data = 8'hFF;
      drain(8, "b2b_3C", 40);
      done_drops(8, "b2b_3C");
   endtask

   task automatic test_reset_mid_frame();
      start_word(8, 8'hF7, PAR_EVEN, 1'b0, 1'b0);
      repeat (17) @(negedge clk);
      n_assert++;
      if (tx8 !== 1'b0 || busy8 !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset_bit3: tx=%b busy=%b expected 0/1", tx8, busy8);
      end
      rst = 1'b1;
      #1;
      n_assert++;
      if (tx8 !== 1'b1 || ready8 !== 1'b1 || busy8 !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: tx=%b ready=%b busy=%b expected 1/1/0", tx8, ready8, busy8);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         n_assert++;
         if (done8 !== 1'b0 || tx8 !== 1'b1 || busy8 !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_quiet cycle %0d: done=%b tx=%b busy=%b expected 0/1/0", i, done8, tx8, busy8);
         end
      end
      push_frame(8'h5A, 8, PAR_EVEN, 1'b0);
      start_word(8, 8'h5A, PAR_EVEN, 1'b0, 1'b0);
      drain(8, "after_reset_5A", 44);
      done_drops(8, "after_reset_5A");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_8n1();
      test_parity();
      test_back_to_back();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
